// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each wide beat lowest index first.
// Define STREAM_DOWNSIZE_KEEP_EN to honour s_keep_i; otherwise every lane of every beat is emitted.
module stream_downsize #(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high.
  // m_valid_o/m_data_o/m_last_o hold until taken; s_ready_o depends combinationally on m_ready_i.

  localparam int SEL_W = $clog2(T_DATA_RATIO);

  typedef enum logic {EMPTY, DRAIN} state_e;

  state_e                  state;
  logic [T_DATA_WIDTH-1:0] buf_data_q [T_DATA_RATIO];
  logic [T_DATA_WIDTH-1:0] buf_data_d [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] rem_q, rem_d;
  logic [T_DATA_RATIO-1:0] load_mask;
  logic                    buf_last_q, buf_last_d;
  logic [SEL_W-1:0]        sel;
  logic                    rem_one;
  logic                    out_fire;
  logic                    in_fire;

`ifdef STREAM_DOWNSIZE_KEEP_EN
  assign load_mask = s_keep_i;
`else
  logic unused_keep;
  assign unused_keep = ^s_keep_i;
  assign load_mask   = '1;
`endif

  assign state   = (rem_q == '0) ? EMPTY : DRAIN;
  assign rem_one = (rem_q != '0) && ((rem_q & (rem_q - T_DATA_RATIO'(1))) == '0);

  // Lowest set bit of rem wins, so scanning from the top lets lower lanes overwrite.
  always_comb begin
    sel = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      if (rem_q[i]) sel = SEL_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q      <= '0;
      buf_last_q <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) buf_data_q[i] <= '0;
    end else begin
      rem_q      <= rem_d;
      buf_last_q <= buf_last_d;
      for (int i = 0; i < T_DATA_RATIO; i++) buf_data_q[i] <= buf_data_d[i];
    end
  end

  // Next-state: a new beat overrides the clear of the lane leaving this cycle.
  always_comb begin
    rem_d      = rem_q;
    buf_last_d = buf_last_q;
    for (int i = 0; i < T_DATA_RATIO; i++) buf_data_d[i] = buf_data_q[i];
    if (out_fire) rem_d[sel] = 1'b0;
    if (in_fire) begin
      rem_d      = load_mask;
      buf_last_d = s_last_i;
      for (int i = 0; i < T_DATA_RATIO; i++) buf_data_d[i] = s_data_i[i];
    end
  end

  // Outputs
  always_comb begin
    m_valid_o = (state == DRAIN);
    m_data_o  = buf_data_q[sel];
    m_last_o  = buf_last_q & rem_one;
    s_ready_o = rst_n && ((state == EMPTY) || ((state == DRAIN) && m_ready_i && rem_one));
  end

  assign out_fire = m_valid_o & m_ready_i;
  assign in_fire  = s_valid_i & s_ready_o;

endmodule

// File: tb/tb_stream_downsize.sv
// Bench for stream_downsize (8-bit lanes, ratio 4): directed scenarios then random traffic,
// checked by a lane-queue reference model and a negedge monitor.
module tb_stream_downsize;

  localparam int W = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_data_i [R];
  logic [R-1:0] s_keep_i = '0;
  logic         s_last_i = 1'b0;
  logic         s_valid_i = 1'b0;
  logic         s_ready_o;
  logic [W-1:0] m_data_o;
  logic         m_last_o;
  logic         m_valid_o;
  logic         m_ready_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int timeouts_seen = 0;
  int timeouts_reported = 0;
  bit rand_ready = 1'b0;
  bit end_chk = 1'b0;
  bit end_done = 1'b0;

  // Expected narrow beats as {last, data}
  logic [W:0] exp_q[$];

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_keep_i(s_keep_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [R*W-1:0] data, input logic [R-1:0] keep, input logic last);
    int cnt;
    for (int i = 0; i < R; i++) s_data_i[i] = data[i*W +: W];
    s_keep_i  = keep;
    s_last_i  = last;
    s_valid_i = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!s_ready_o && cnt < 200) begin
      step();
      @(negedge clk);
      cnt++;
    end
    if (!s_ready_o) timeouts_seen++;
    step();
    s_valid_i = 1'b0;
  endtask

  // Scoreboard / monitor
  logic         stall_q = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  bit           post_reset = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_q    = 1'b0;
      post_reset = 1'b1;
    end else begin
      if (post_reset) begin
        chk("reset_valid", 32'(m_valid_o), 32'd0);
        chk("reset_data", 32'(m_data_o), 32'd0);
        chk("reset_last", 32'(m_last_o), 32'd0);
        post_reset = 1'b0;
      end
      chk("m_valid", 32'(m_valid_o), 32'(exp_q.size() != 0));
      chk("s_ready", 32'(s_ready_o),
          32'((exp_q.size() == 0) || (m_ready_i && exp_q.size() == 1)));
      if (!m_valid_o) chk("idle_last", 32'(m_last_o), 32'd0);
      if (stall_q) begin
        chk("hold_data", 32'(m_data_o), 32'(prev_data));
        chk("hold_last", 32'(m_last_o), 32'(prev_last));
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_valid_o), 32'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("m_data", 32'(m_data_o), 32'(e[W-1:0]));
          chk("m_last", 32'(m_last_o), 32'(e[W]));
        end
      end
      stall_q   = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      prev_last = m_last_o;
      // Reference model: kept lanes in ascending order, last on the highest kept lane.
      if (s_valid_i && s_ready_o) begin
        logic [R-1:0] en;
        int hi;
`ifdef STREAM_DOWNSIZE_KEEP_EN
        en = s_keep_i;
`else
        en = '1;
`endif
        hi = -1;
        for (int i = 0; i < R; i++) if (en[i]) hi = i;
        for (int i = 0; i < R; i++)
          if (en[i]) exp_q.push_back({s_last_i && (i == hi), s_data_i[i]});
      end
    end
    if (timeouts_seen > timeouts_reported) begin
      timeouts_reported++;
      chk("accept_timeout", 32'd1, 32'd0);
    end
    if (end_chk && !end_done) begin
      chk("drained", 32'(exp_q.size()), 32'd0);
      end_done = 1'b1;
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < R; i++) s_data_i[i] = '0;
    repeat (3) step();
    rst_n = 1'b1;
    m_ready_i = 1'b1;
    step();

    send(32'h44332211, 4'b1111, 1'b1);
    repeat (5) step();
    send(32'h44332211, 4'b0101, 1'b1);
    repeat (5) step();

    send(32'h44332211, 4'b1111, 1'b1);
    m_ready_i = 1'b0;
    repeat (3) step();
    m_ready_i = 1'b1;
    repeat (5) step();

    send(32'h88776655, 4'b1111, 1'b0);
    send(32'h44332211, 4'b1111, 1'b1);
    repeat (10) step();

    send(32'hdeadbeef, 4'b0000, 1'b1);
    repeat (3) step();

    send(32'h44332211, 4'b1111, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();

    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) step();
    end
    rand_ready = 1'b0;
    m_ready_i  = 1'b1;
    repeat (20) step();
    end_chk = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
